// File: rtl/dvp_tsmap_pkg.sv
// dvp_tsmap_pkg
// Shared definitions for the tsmap (temporal-safety revocation map) checkers.
// Holds the checker FSM state encoding, the default tsmap base address and
// the granule constants that turn a byte address into a word/bit position.
// No ports (package).
package dvp_tsmap_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } tsmap_state_t;

  // Byte address covered by tsmap word 0 unless overridden
  localparam logic [31:0] TSMAP_BASE_DEFAULT = 32'h8000_0000;

  // One revocation bit covers an 8-byte granule; a 32-bit word covers 256 bytes
  localparam int unsigned GRANULE_BYTES   = 8;
  localparam int unsigned WORD_SPAN_BYTES = 256;
  localparam int unsigned GRANULE_SHIFT   = 3;
  localparam int unsigned WORD_SHIFT      = 8;

  // Width of the bit-in-word index and of the tsmap word index
  localparam int unsigned BIT_IDX_W  = WORD_SHIFT - GRANULE_SHIFT;
  localparam int unsigned WORD_IDX_W = 13;

endpackage

// File: rtl/dma_tsmap_checker.sv
// dma_tsmap_checker
// Looks up the revocation bit for a capability base address on behalf of a
// DMA engine. The address is translated to a tsmap word/bit, the word is read
// through a tsmap port shared with the CPU (retrying while the CPU holds the
// port), and the selected bit is returned as a valid/ready response.
//
// Optional feature: define DMA_TSMAP_SNOOP_EN to let a CPU read of the same
// tsmap word (seen on the snooped_* inputs) answer the request directly while
// waiting for the port. Without the macro the snooped_* inputs are ignored.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid_i/req_ready_o   request handshake, req_addr_i = address to check
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_revoked_o             revocation bit for the requested granule
//   rsp_error_o               address outside the tsmap or retries exhausted
//   dma_tsmap_cs_o/_addr_o    tsmap read request (word index)
//   dma_tsmap_rdata_i         tsmap read data, one cycle after a won request
//   tsmap_is_occupied_i       CPU owns the tsmap port this cycle
//   snooped_tsmap_*           CPU tsmap access (select, word, data) same cycle
module dma_tsmap_checker
  import dvp_tsmap_pkg::*;
#(
  parameter logic [31:0] TSMAP_BASE  = TSMAP_BASE_DEFAULT,
  parameter int unsigned TSMAP_WORDS = 8192,
  parameter int unsigned MAX_RETRY   = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_revoked_o,
  output logic        rsp_error_o,
  output logic        dma_tsmap_cs_o,
  output logic [15:0] dma_tsmap_addr_o,
  input  logic [31:0] dma_tsmap_rdata_i,
  input  logic        tsmap_is_occupied_i,
  input  logic        snooped_tsmap_cs_i,
  input  logic [15:0] snooped_tsmap_addr_i,
  input  logic [31:0] snooped_tsmap_rdata_i
);

  // A zero retry budget still needs a one-bit counter
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [31:0] WORDS_LIMIT = 32'(TSMAP_WORDS);

  tsmap_state_t          state;
  logic [RETRY_W-1:0]    retry;
  logic [WORD_IDX_W-1:0] word_q;
  logic [BIT_IDX_W-1:0]  bit_q;

  logic [31:0] offset;
  logic        out_of_range;
  logic        issuing;
  logic        snoop_hit;
  logic        snoop_bit;
  logic        unused_bits;

  // Address translation. The subtraction is unsigned, so an address below the
  // base wraps to a huge offset and is caught by the same range compare.
  assign offset       = req_addr_i - TSMAP_BASE;
  assign out_of_range = (offset >> WORD_SHIFT) >= WORDS_LIMIT;

  // The tsmap request is driven straight from the state so the port sees it
  // in the same cycle the FSM decides to issue; reset blanks it immediately.
  assign issuing          = rstn && (state == ISSUE);
  assign dma_tsmap_cs_o   = issuing;
  assign dma_tsmap_addr_o = issuing ? {{(16 - WORD_IDX_W){1'b0}}, word_q} : 16'h0000;
  assign req_ready_o      = rstn && (state == IDLE);

`ifdef DMA_TSMAP_SNOOP_EN
  // A CPU read of our word carries exactly the data we are waiting for
  assign snoop_hit   = snooped_tsmap_cs_i && (snooped_tsmap_addr_i[WORD_IDX_W-1:0] == word_q);
  assign snoop_bit   = snooped_tsmap_rdata_i[bit_q];
  assign unused_bits = ^{offset[GRANULE_SHIFT-1:0], snooped_tsmap_addr_i[15:WORD_IDX_W]};
`else
  assign snoop_hit   = 1'b0;
  assign snoop_bit   = 1'b0;
  assign unused_bits = ^{offset[GRANULE_SHIFT-1:0], snooped_tsmap_cs_i,
                         snooped_tsmap_addr_i, snooped_tsmap_rdata_i};
`endif

  // Request FSM with registered response outputs. The retry counter only
  // advances while below its limit, so it can never wrap; reaching the limit
  // with the port still taken ends the request with an error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      retry         <= '0;
      word_q        <= '0;
      bit_q         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_revoked_o <= 1'b0;
      rsp_error_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            word_q <= offset[WORD_SHIFT +: WORD_IDX_W];
            bit_q  <= offset[GRANULE_SHIFT +: BIT_IDX_W];
            retry  <= '0;
            if (out_of_range) begin
              state         <= RESP;
              rsp_valid_o   <= 1'b1;
              rsp_revoked_o <= 1'b0;
              rsp_error_o   <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (snoop_hit) begin
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_revoked_o <= snoop_bit;
            rsp_error_o   <= 1'b0;
          end else if (!tsmap_is_occupied_i) begin
            state <= CAPTURE;
          end else if (retry == RETRY_LIMIT) begin
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_revoked_o <= 1'b0;
            rsp_error_o   <= 1'b1;
          end else begin
            retry <= retry + 1'b1;
          end
        end

        CAPTURE: begin
          state         <= RESP;
          rsp_valid_o   <= 1'b1;
          rsp_revoked_o <= dma_tsmap_rdata_i[bit_q];
          rsp_error_o   <= 1'b0;
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_tsmap_checker.sv
// tb_dma_tsmap_checker
// Self-checking bench for dma_tsmap_checker: a directed table of corner
// cases, hand-written reset and snoop sequences, then randomized requests
// checked against a behavioural model of the tsmap lookup.
// Honours DMA_TSMAP_SNOOP_EN for the snoop expectations.
module tb_dma_tsmap_checker;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 8192;
  localparam int          MAXR  = 15;
  localparam int          LAT_BOUND = 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_revoked_o;
  logic        rsp_error_o;
  logic        dma_tsmap_cs_o;
  logic [15:0] dma_tsmap_addr_o;
  logic [31:0] dma_tsmap_rdata_i;
  logic        tsmap_is_occupied_i;
  logic        snooped_tsmap_cs_i;
  logic [15:0] snooped_tsmap_addr_i;
  logic [31:0] snooped_tsmap_rdata_i;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] mem [WORDS];

  typedef struct {
    logic [31:0] addr;
    int          occ;
    int          bp;
    logic        exp_rev;
    logic        exp_err;
    int          exp_lat;
    int          exp_cs;
  } vec_t;

  vec_t vecs [13];

  dma_tsmap_checker #(
    .TSMAP_BASE (BASE),
    .TSMAP_WORDS(WORDS),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_addr_i           (req_addr_i),
    .rsp_valid_o          (rsp_valid_o),
    .rsp_ready_i          (rsp_ready_i),
    .rsp_revoked_o        (rsp_revoked_o),
    .rsp_error_o          (rsp_error_o),
    .dma_tsmap_cs_o       (dma_tsmap_cs_o),
    .dma_tsmap_addr_o     (dma_tsmap_addr_o),
    .dma_tsmap_rdata_i    (dma_tsmap_rdata_i),
    .tsmap_is_occupied_i  (tsmap_is_occupied_i),
    .snooped_tsmap_cs_i   (snooped_tsmap_cs_i),
    .snooped_tsmap_addr_i (snooped_tsmap_addr_i),
    .snooped_tsmap_rdata_i(snooped_tsmap_rdata_i)
  );

  always #5 clk = ~clk;

  // Shared tsmap port: a won request returns the word one cycle later;
  // any other cycle the bus carries unrelated CPU traffic.
  always @(posedge clk) begin
    if (dma_tsmap_cs_o && !tsmap_is_occupied_i)
      dma_tsmap_rdata_i <= mem[dma_tsmap_addr_o[12:0]];
    else
      dma_tsmap_rdata_i <= $urandom;
  end

  // Hard stop if something never returns control
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Behavioural model of one lookup: result plus timing, from the address
  // arithmetic and the number of cycles the CPU keeps the port.
  function automatic void model(input logic [31:0] addr, input int occ,
                                output logic rev, output logic err,
                                output int lat, output int cs);
    logic [31:0] off;
    int          word;
    int          bitn;
    off = addr - BASE;
    if ((off / 256) >= WORDS) begin
      rev = 1'b0; err = 1'b1; lat = 1; cs = 0;
    end else if (occ > MAXR) begin
      rev = 1'b0; err = 1'b1; lat = MAXR + 2; cs = MAXR + 1;
    end else begin
      word = int'(off / 256);
      bitn = int'((off % 256) / 8);
      rev  = mem[word][bitn];
      err  = 1'b0; lat = occ + 3; cs = occ + 1;
    end
  endfunction

  // Runs one request end to end: occupies the port for the first occ issue
  // cycles, optionally snoops the matching word, holds the response for bp
  // cycles of backpressure, and checks everything against the expectations.
  task automatic applyStimulus(input logic [31:0] addr, input int occ, input int bp, input bit snoop,
                               input logic exp_rev, input logic exp_err,
                               input int exp_lat, input int exp_cs);
    logic [31:0] off;
    logic [12:0] w;
    logic [4:0]  b;
    int          cyc;
    int          cs_cnt;
    off    = addr - BASE;
    w      = off[20:8];
    b      = off[7:3];
    cs_cnt = 0;

    @(negedge clk);
    tsmap_is_occupied_i = 1'b0;
    snooped_tsmap_cs_i  = 1'b0;
    checkOutput("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    cyc = 1;
    while (!rsp_valid_o && cyc <= LAT_BOUND) begin
      if (dma_tsmap_cs_o) begin
        cs_cnt++;
        checkOutput("tsmap_addr", 32'(dma_tsmap_addr_o), 32'(w));
        tsmap_is_occupied_i = (cs_cnt <= occ);
        if (snoop) begin
          snooped_tsmap_cs_i    = 1'b1;
          snooped_tsmap_addr_i  = {3'b000, w};
          snooped_tsmap_rdata_i = 32'h1 << b;
        end else begin
          snooped_tsmap_cs_i    = 1'($urandom_range(0, 1));
          snooped_tsmap_addr_i  = {3'b000, w ^ 13'h0001};
          snooped_tsmap_rdata_i = $urandom;
        end
      end else begin
        tsmap_is_occupied_i   = 1'($urandom_range(0, 1));
        snooped_tsmap_cs_i    = 1'b0;
        snooped_tsmap_rdata_i = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    tsmap_is_occupied_i = 1'b0;
    snooped_tsmap_cs_i  = 1'b0;

    checkOutput("latency", 32'(cyc), 32'(exp_lat));
    checkOutput("cs_cycles", 32'(cs_cnt), 32'(exp_cs));
    checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("rsp_revoked", 32'(rsp_revoked_o), 32'(exp_rev));
    checkOutput("rsp_error", 32'(rsp_error_o), 32'(exp_err));

    rsp_ready_i = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      tsmap_is_occupied_i = 1'($urandom_range(0, 1));
      checkOutput("bp_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("bp_revoked", 32'(rsp_revoked_o), 32'(exp_rev));
      checkOutput("bp_error", 32'(rsp_error_o), 32'(exp_err));
      checkOutput("bp_ready_low", 32'(req_ready_o), 32'd0);
      checkOutput("bp_no_cs", 32'(dma_tsmap_cs_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i         = 1'b0;
    tsmap_is_occupied_i = 1'b0;
    checkOutput("valid_drop", 32'(rsp_valid_o), 32'd0);
    checkOutput("ready_back", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    logic        m_rev;
    logic        m_err;
    int          m_lat;
    int          m_cs;
    logic [31:0] r_addr;
    int          r_occ;

    rstn                  = 1'b0;
    req_valid_i           = 1'b0;
    req_addr_i            = '0;
    rsp_ready_i           = 1'b0;
    tsmap_is_occupied_i   = 1'b0;
    snooped_tsmap_cs_i    = 1'b0;
    snooped_tsmap_addr_i  = '0;
    snooped_tsmap_rdata_i = '0;
    dma_tsmap_rdata_i     = '0;

    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0]    = 32'hFFFF_FFFE;
    mem[1]    = 32'h0000_0200;
    mem[2]    = 32'h0000_0000;
    mem[8191] = 32'h8000_0000;

    // Directed vectors: addr, occupied cycles, backpressure, rev, err, latency, cs cycles
    vecs[0]  = '{32'h8000_0148,  0, 0, 1'b1, 1'b0,  3,  1};
    vecs[1]  = '{32'h7FFF_FFF8,  0, 0, 1'b0, 1'b1,  1,  0};
    vecs[2]  = '{32'h8000_0147,  0, 1, 1'b0, 1'b0,  3,  1};
    vecs[3]  = '{32'h8000_0000,  0, 0, 1'b0, 1'b0,  3,  1};
    vecs[4]  = '{32'h8000_0008,  0, 0, 1'b1, 1'b0,  3,  1};
    vecs[5]  = '{32'h801F_FFF8,  0, 0, 1'b1, 1'b0,  3,  1};
    vecs[6]  = '{32'h8020_0000,  0, 0, 1'b0, 1'b1,  1,  0};
    vecs[7]  = '{32'hFFFF_FFFF,  0, 0, 1'b0, 1'b1,  1,  0};
    vecs[8]  = '{32'h8000_0148,  4, 0, 1'b1, 1'b0,  7,  5};
    vecs[9]  = '{32'h8000_0148, 16, 0, 1'b0, 1'b1, 17, 16};
    vecs[10] = '{32'h8000_0148, 15, 0, 1'b1, 1'b0, 18, 16};
    vecs[11] = '{32'h8000_0148, 20, 2, 1'b0, 1'b1, 17, 16};
    vecs[12] = '{32'h8000_0148,  0, 5, 1'b1, 1'b0,  3,  1};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_cs", 32'(dma_tsmap_cs_o), 32'd0);
    checkOutput("rst_addr", 32'(dma_tsmap_addr_o), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_revoked", 32'(rsp_revoked_o), 32'd0);
    checkOutput("rst_error", 32'(rsp_error_o), 32'd0);
    rstn = 1'b1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].occ, vecs[i].bp, 1'b0,
                    vecs[i].exp_rev, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_cs);
    end

    // Reset while the word is being captured: the pending response (which
    // would be revoked=1) must vanish and the next request must work.
    $display("[TB] reset during capture");
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h8000_0148;
    @(negedge clk);
    req_valid_i = 1'b0;
    checkOutput("pre_rst_issue", 32'(dma_tsmap_cs_o), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    checkOutput("rst_mid_cs", 32'(dma_tsmap_cs_o), 32'd0);
    checkOutput("rst_mid_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_mid_revoked", 32'(rsp_revoked_o), 32'd0);
    checkOutput("rst_mid_error", 32'(rsp_error_o), 32'd0);
    checkOutput("rst_mid_addr", 32'(dma_tsmap_addr_o), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      checkOutput("post_rst_ready", 32'(req_ready_o), 32'd1);
    end
    applyStimulus(32'h8000_0148, 0, 0, 1'b0, 1'b1, 1'b0, 3, 1);

    // Snoop while the port is held: word 2 in memory is all zero, the
    // snooped copy has the bit set, so the source of the answer is visible.
    $display("[TB] snoop sequence");
`ifdef DMA_TSMAP_SNOOP_EN
    applyStimulus(32'h8000_0248, 3, 0, 1'b1, 1'b1, 1'b0, 2, 1);
`else
    applyStimulus(32'h8000_0248, 3, 0, 1'b1, 1'b0, 1'b0, 6, 4);
`endif

    $display("[TB] randomized requests");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8)
        r_addr = BASE + 32'($urandom_range(0, WORDS * 256 - 1));
      else
        r_addr = $urandom;
      if ($urandom_range(0, 9) < 7)
        r_occ = $urandom_range(0, 3);
      else
        r_occ = $urandom_range(0, 18);
      model(r_addr, r_occ, m_rev, m_err, m_lat, m_cs);
      applyStimulus(r_addr, r_occ, $urandom_range(0, 3), 1'b0, m_rev, m_err, m_lat, m_cs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dma_tsmap_checker.md
DMA_TSMAP_CHECKER -- requirements
Module: dma_tsmap_checker

Interface
REQ-001 SHALL provide parameter TSMAP_BASE, default 32'h8000_0000: byte address covered by tsmap word 0.
REQ-002 SHALL provide parameter TSMAP_WORDS, default 8192: number of 32-bit tsmap words; one bit per 8 bytes, so one word per 256 bytes.
REQ-003 SHALL provide parameter MAX_RETRY, default 15: maximum lost arbitration attempts before an error response.
REQ-004 SHALL have ports clk input 1 (clock) and rstn input 1 (reset); reset rstn, synchronous, active-low; clock clk.
REQ-005 SHALL have req_valid_i input 1 (check request) and req_ready_o output 1 (request accepted).
REQ-006 SHALL have req_addr_i input 32 (capability base byte address to check).
REQ-007 SHALL have rsp_valid_o output 1 (response valid) and rsp_ready_i input 1 (response consumed).
REQ-008 SHALL have rsp_revoked_o output 1 (revocation bit) and rsp_error_o output 1 (out of range or retry exhausted).
REQ-009 SHALL have dma_tsmap_cs_o output 1, dma_tsmap_addr_o output 16, dma_tsmap_rdata_i input 32, tsmap_is_occupied_i input 1 (CPU holds the tsmap port this cycle).
REQ-010 SHALL have snooped_tsmap_cs_i input 1, snooped_tsmap_addr_i input 16, snooped_tsmap_rdata_i input 32 (CPU read result, all three aligned to the same cycle).

Function
REQ-011 SHALL use a FSM with states IDLE, ISSUE, CAPTURE, RESP.
REQ-012 SHALL assert req_ready_o only in IDLE; on req_valid_i&&req_ready_o it SHALL latch the address, compute offset = req_addr_i - TSMAP_BASE (32-bit, unsigned), word = offset[31:8], bit = offset[7:3].
REQ-013 SHALL treat word >= TSMAP_WORDS (including wrap when req_addr_i < TSMAP_BASE) as out of range and go IDLE->RESP with rsp_error_o=1, rsp_revoked_o=0, issuing no tsmap access.
REQ-014 SHALL go IDLE->ISSUE for an in-range address, with retry counter cleared.
REQ-015 SHALL, in ISSUE, assert dma_tsmap_cs_o=1 and dma_tsmap_addr_o={3'b0,word[12:0]} combinationally, zero in all other states.
REQ-016 SHALL, in ISSUE with tsmap_is_occupied_i=0, go to CAPTURE; with tsmap_is_occupied_i=1, increment retry and stay in ISSUE.
REQ-017 SHALL, in ISSUE when retry==MAX_RETRY and the port is still occupied, go to RESP with rsp_error_o=1, rsp_revoked_o=0.
REQ-018 SHALL, in CAPTURE, register rsp_revoked_o=dma_tsmap_rdata_i[bit] and rsp_error_o=0, then go to RESP; fixed latency request-to-response is 3 cycles when uncontended.
REQ-019 SHALL hold rsp_valid_o=1 with stable data in RESP until rsp_ready_i=1, then return to IDLE; a new request is accepted at the earliest one cycle later.
REQ-020 SHALL saturate the retry counter width at clog2(MAX_RETRY+1) bits; no wrap.

Reset
REQ-021 SHALL, when rstn=0 at a clock edge, force IDLE, retry=0, rsp_valid_o=0, rsp_revoked_o=0, rsp_error_o=0, dma_tsmap_cs_o=0, dma_tsmap_addr_o=0, req_ready_o=0 during reset.
REQ-022 SHALL abandon any in-flight request on reset mid-operation with no response generated; data arriving on dma_tsmap_rdata_i afterwards SHALL be ignored.

Configuration
REQ-023 SHALL, with DMA_TSMAP_SNOOP_EN defined, resolve in ISSUE when snooped_tsmap_cs_i=1 and snooped_tsmap_addr_i[12:0]==word[12:0]: go directly to RESP with rsp_revoked_o=snooped_tsmap_rdata_i[bit], without waiting for arbitration; snoop hit takes priority over a loss in the same cycle.
REQ-024 SHALL, without DMA_TSMAP_SNOOP_EN, ignore all snooped_* inputs entirely (ports remain present).

Structure
REQ-025 SHALL place the FSM state enum, TSMAP_BASE default and the 8-byte/256-byte granule constants in shared package dvp_tsmap_pkg.
REQ-026 SHALL be a single module with no sub-modules; the address translator is inline logic.

Verification
REQ-027 Uncontended: req_addr_i=32'h8000_0148, rdata word 1 = 32'h0000_0200 -> dma_tsmap_addr_o=1 in ISSUE, rsp_revoked_o=1 (bit 9), rsp_error_o=0, rsp_valid_o 3 cycles after accept.
REQ-028 Out of range: req_addr_i=32'h7FFF_FFF8 -> no dma_tsmap_cs_o, rsp_error_o=1, rsp_revoked_o=0 next cycle.
REQ-029 Contention: tsmap_is_occupied_i=1 for 4 cycles then 0 -> dma_tsmap_cs_o high 5 cycles, correct bit returned; occupied held 16+ cycles -> rsp_error_o=1 after exactly 16 ISSUE cycles.
REQ-030 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0 throughout.
REQ-031 Snoop (DMA_TSMAP_SNOOP_EN): snooped cs=1, addr matching word, rdata bit set while occupied -> rsp_revoked_o=1, no CAPTURE; without macro -> waits for arbitration.
REQ-032 Reset in CAPTURE: rstn=0 one cycle -> all outputs 0, no response, next request handled normally.
